// File: rtl/segre_dtlb.sv
// Fully-associative, software-refilled data TLB: combinational lookup of the
// TL-stage virtual address, FIFO replacement, miss state held until fill/flush.
module segre_dtlb #(
    parameter int VADDR_SIZE       = 32,
    parameter int PADDR_SIZE       = 20,
    parameter int TLB_NUM_ENTRYS   = 4,
    parameter int PAGE_OFFSET_SIZE = 12,
    localparam int VPN_SIZE        = VADDR_SIZE - PAGE_OFFSET_SIZE,
    localparam int PPN_SIZE        = PADDR_SIZE - PAGE_OFFSET_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  req_i,
    input  logic [VADDR_SIZE-1:0] vaddr_i,
    input  logic                  supervisor_i,
    input  logic                  flush_i,
    input  logic                  fill_i,
    input  logic [VPN_SIZE-1:0]   fill_vpn_i,
    input  logic [PPN_SIZE-1:0]   fill_ppn_i,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic [PADDR_SIZE-1:0] paddr_o,
    output logic [VPN_SIZE-1:0]   miss_vpn_o
);

    localparam int PTR_W = $clog2(TLB_NUM_ENTRYS);

    typedef enum logic {TLB_IDLE, TLB_MISS} state_e;

    state_e                     state_q, state_d;
    logic [TLB_NUM_ENTRYS-1:0]  valid_q, valid_d;
    logic [VPN_SIZE-1:0]        vpn_q [TLB_NUM_ENTRYS];
    logic [PPN_SIZE-1:0]        ppn_q [TLB_NUM_ENTRYS];
    logic [PTR_W-1:0]           fifo_ptr_q, fifo_ptr_d;
    logic [VPN_SIZE-1:0]        miss_vpn_q, miss_vpn_d;

    logic [VPN_SIZE-1:0]        lookup_vpn;
    logic                       lookup_match;
    logic [PPN_SIZE-1:0]        lookup_ppn;
    logic                       fill_match;
    logic [PTR_W-1:0]           fill_match_idx;
    logic                       fill_we;
    logic [PTR_W-1:0]           fill_idx;

    assign lookup_vpn = vaddr_i[VADDR_SIZE-1:PAGE_OFFSET_SIZE];

    // Entries are unique by construction, so OR-ing the matching PPNs selects the single hit.
    always_comb begin
        lookup_match   = 1'b0;
        lookup_ppn     = '0;
        fill_match     = 1'b0;
        fill_match_idx = '0;
        for (int i = 0; i < TLB_NUM_ENTRYS; i++) begin
            if (valid_q[i] && vpn_q[i] == lookup_vpn) begin
                lookup_match = 1'b1;
                lookup_ppn   = lookup_ppn | ppn_q[i];
            end
            if (valid_q[i] && vpn_q[i] == fill_vpn_i) begin
                fill_match     = 1'b1;
                fill_match_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        hit_o   = 1'b0;
        miss_o  = 1'b0;
        paddr_o = '0;
        if (state_q == TLB_MISS) begin
            miss_o = 1'b1;
        end else if (req_i && (supervisor_i || lookup_match)) begin
            hit_o   = 1'b1;
            paddr_o = supervisor_i ? vaddr_i[PADDR_SIZE-1:0]
                                   : {lookup_ppn, vaddr_i[PAGE_OFFSET_SIZE-1:0]};
        end
    end

    assign miss_vpn_o = miss_vpn_q;

    // A refill of an already-present VPN rewrites in place so duplicates never exist.
    assign fill_we  = fill_i && !flush_i;
    assign fill_idx = fill_match ? fill_match_idx : fifo_ptr_q;

    // NOTE: every signal written here is given a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        fifo_ptr_d = fifo_ptr_q;
        miss_vpn_d = miss_vpn_q;

        if (flush_i) begin
            valid_d    = '0;
            fifo_ptr_d = '0;
            state_d    = TLB_IDLE;
        end else begin
            if (fill_we) begin
                valid_d[fill_idx] = 1'b1;
                if (!fill_match) fifo_ptr_d = fifo_ptr_q + PTR_W'(1);
            end
            case (state_q)
                TLB_IDLE: begin
                    // Lookup sees pre-fill contents, so a concurrent fill does not suppress the miss.
                    if (req_i && !supervisor_i && !lookup_match) begin
                        miss_vpn_d = lookup_vpn;
                        state_d    = TLB_MISS;
                    end
                end
                TLB_MISS: begin
                    if (fill_i) state_d = TLB_IDLE;
                end
                default: state_d = TLB_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q    <= TLB_IDLE;
            valid_q    <= '0;
            fifo_ptr_q <= '0;
            miss_vpn_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            fifo_ptr_q <= fifo_ptr_d;
            miss_vpn_q <= miss_vpn_d;
        end
    end

    // NOTE: tag/data arrays are not reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            vpn_q[fill_idx] <= fill_vpn_i;
            ppn_q[fill_idx] <= fill_ppn_i;
        end
    end

endmodule

// File: tb/tb_segre_dtlb.sv
// Directed self-checking bench for segre_dtlb: inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_segre_dtlb;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        req_i;
    logic [31:0] vaddr_i;
    logic        supervisor_i;
    logic        flush_i;
    logic        fill_i;
    logic [19:0] fill_vpn_i;
    logic [7:0]  fill_ppn_i;
    logic        hit_o;
    logic        miss_o;
    logic [19:0] paddr_o;
    logic [19:0] miss_vpn_o;

    int n_checks = 0;
    int n_errors = 0;

    segre_dtlb dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .req_i        (req_i),
        .vaddr_i      (vaddr_i),
        .supervisor_i (supervisor_i),
        .flush_i      (flush_i),
        .fill_i       (fill_i),
        .fill_vpn_i   (fill_vpn_i),
        .fill_ppn_i   (fill_ppn_i),
        .hit_o        (hit_o),
        .miss_o       (miss_o),
        .paddr_o      (paddr_o),
        .miss_vpn_o   (miss_vpn_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic drive(input logic req, input logic [31:0] va, input logic sup,
                         input logic fl, input logic fi,
                         input logic [19:0] fv, input logic [7:0] fp);
        @(negedge clk_i);
        req_i = req; vaddr_i = va; supervisor_i = sup;
        flush_i = fl; fill_i = fi; fill_vpn_i = fv; fill_ppn_i = fp;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    endtask

    task automatic lookup(input logic [31:0] va);
        drive(1'b1, va, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    endtask

    task automatic fill(input logic [19:0] fv, input logic [7:0] fp);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, fv, fp);
    endtask

    task automatic flush();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 20'h0, 8'h0);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rsn_i = 1'b0; req_i = 1'b0; vaddr_i = '0; supervisor_i = 1'b0;
        flush_i = 1'b0; fill_i = 1'b0; fill_vpn_i = '0; fill_ppn_i = '0;
        repeat (2) @(negedge clk_i);
        rsn_i = 1'b1;
        #1;
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL reset_hit: got %b want 0", hit_o); end
        n_checks++; if (miss_o !== 1'b0) begin n_errors++; $display("FAIL reset_miss: got %b want 0", miss_o); end
        n_checks++; if (paddr_o !== 20'h0) begin n_errors++; $display("FAIL reset_paddr: got %h want 00000", paddr_o); end
        n_checks++; if (miss_vpn_o !== 20'h0) begin n_errors++; $display("FAIL reset_miss_vpn: got %h want 00000", miss_vpn_o); end
    endtask

    task automatic test_miss_then_fill();
        lookup(32'h0000_5123);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL first_lookup_hit: got %b want 0", hit_o); end
        n_checks++; if (paddr_o !== 20'h0) begin n_errors++; $display("FAIL first_lookup_paddr: got %h want 00000", paddr_o); end
        idle();
        n_checks++; if (miss_o !== 1'b1) begin n_errors++; $display("FAIL miss_asserted: got %b want 1", miss_o); end
        n_checks++; if (miss_vpn_o !== 20'h00005) begin n_errors++; $display("FAIL miss_vpn: got %h want 00005", miss_vpn_o); end
        // Supervisor access while a miss is pending neither hits nor clears it.
        drive(1'b1, 32'h0000_5123, 1'b1, 1'b0, 1'b0, 20'h0, 8'h0);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL sup_in_miss_hit: got %b want 0", hit_o); end
        n_checks++; if (miss_o !== 1'b1) begin n_errors++; $display("FAIL sup_in_miss_miss: got %b want 1", miss_o); end
        drive(1'b1, 32'h0000_5123, 1'b0, 1'b0, 1'b1, 20'h00005, 8'hA3);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL fill_cycle_hit: got %b want 0", hit_o); end
        lookup(32'h0000_5123);
        n_checks++; if (miss_o !== 1'b0) begin n_errors++; $display("FAIL after_fill_miss: got %b want 0", miss_o); end
        n_checks++; if (hit_o !== 1'b1) begin n_errors++; $display("FAIL after_fill_hit: got %b want 1", hit_o); end
        n_checks++; if (paddr_o !== 20'hA3123) begin n_errors++; $display("FAIL after_fill_paddr: got %h want a3123", paddr_o); end
    endtask

    task automatic test_fifo_eviction();
        flush();
        for (int i = 1; i <= 5; i++) fill(20'(i), 8'(8'h10 + i));
        lookup(32'h0000_5456);
        n_checks++; if (paddr_o !== 20'h15456 || hit_o !== 1'b1) begin n_errors++; $display("FAIL evict_vpn5: got hit=%b paddr=%h want hit=1 paddr=15456", hit_o, paddr_o); end
        lookup(32'h0000_2000);
        n_checks++; if (paddr_o !== 20'h12000 || hit_o !== 1'b1) begin n_errors++; $display("FAIL evict_vpn2: got hit=%b paddr=%h want hit=1 paddr=12000", hit_o, paddr_o); end
        lookup(32'h0000_4FFF);
        n_checks++; if (paddr_o !== 20'h14FFF || hit_o !== 1'b1) begin n_errors++; $display("FAIL evict_vpn4: got hit=%b paddr=%h want hit=1 paddr=14fff", hit_o, paddr_o); end
        lookup(32'h0000_1234);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL evicted_vpn1_hit: got %b want 0", hit_o); end
        idle();
        n_checks++; if (miss_o !== 1'b1 || miss_vpn_o !== 20'h00001) begin n_errors++; $display("FAIL evicted_vpn1_miss: got miss=%b vpn=%h want miss=1 vpn=00001", miss_o, miss_vpn_o); end
    endtask

    task automatic test_refill_existing();
        // Still in TLB_MISS: a dedup refill also releases the miss.
        fill(20'h00003, 8'h77);
        lookup(32'h0000_3ABC);
        n_checks++; if (miss_o !== 1'b0) begin n_errors++; $display("FAIL refill_release_miss: got %b want 0", miss_o); end
        n_checks++; if (paddr_o !== 20'h77ABC || hit_o !== 1'b1) begin n_errors++; $display("FAIL refill_vpn3: got hit=%b paddr=%h want hit=1 paddr=77abc", hit_o, paddr_o); end
        lookup(32'h0000_5000);
        n_checks++; if (paddr_o !== 20'h15000 || hit_o !== 1'b1) begin n_errors++; $display("FAIL refill_keep_vpn5: got hit=%b paddr=%h want hit=1 paddr=15000", hit_o, paddr_o); end
        lookup(32'h0000_2000);
        n_checks++; if (paddr_o !== 20'h12000 || hit_o !== 1'b1) begin n_errors++; $display("FAIL refill_keep_vpn2: got hit=%b paddr=%h want hit=1 paddr=12000", hit_o, paddr_o); end
        // fifo_ptr must still be 1, so the next new VPN replaces VPN 2, not VPN 3.
        fill(20'h00006, 8'h16);
        lookup(32'h0000_6001);
        n_checks++; if (paddr_o !== 20'h16001 || hit_o !== 1'b1) begin n_errors++; $display("FAIL ptr_vpn6: got hit=%b paddr=%h want hit=1 paddr=16001", hit_o, paddr_o); end
        lookup(32'h0000_3ABC);
        n_checks++; if (paddr_o !== 20'h77ABC || hit_o !== 1'b1) begin n_errors++; $display("FAIL ptr_keep_vpn3: got hit=%b paddr=%h want hit=1 paddr=77abc", hit_o, paddr_o); end
        lookup(32'h0000_2000);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL ptr_evict_vpn2: got %b want 0", hit_o); end
        idle();
        n_checks++; if (miss_o !== 1'b1 || miss_vpn_o !== 20'h00002) begin n_errors++; $display("FAIL ptr_vpn2_miss: got miss=%b vpn=%h want miss=1 vpn=00002", miss_o, miss_vpn_o); end
    endtask

    task automatic test_flush_fill();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 20'h00009, 8'h99);
        lookup(32'h0000_9000);
        n_checks++; if (miss_o !== 1'b0) begin n_errors++; $display("FAIL flush_abort_miss: got %b want 0", miss_o); end
        n_checks++; if (miss_vpn_o !== 20'h00002) begin n_errors++; $display("FAIL flush_keep_miss_vpn: got %h want 00002", miss_vpn_o); end
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL flush_drop_fill_vpn9: got %b want 0", hit_o); end
        idle();
        n_checks++; if (miss_o !== 1'b1 || miss_vpn_o !== 20'h00009) begin n_errors++; $display("FAIL flush_vpn9_miss: got miss=%b vpn=%h want miss=1 vpn=00009", miss_o, miss_vpn_o); end
        flush();
        lookup(32'h0000_5000);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL flush_clear_vpn5: got %b want 0", hit_o); end
        flush();
        lookup(32'h0000_3ABC);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL flush_clear_vpn3: got %b want 0", hit_o); end
        flush();
    endtask

    task automatic test_supervisor();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 20'h0, 8'h0);
        n_checks++; if (hit_o !== 1'b1) begin n_errors++; $display("FAIL sup_hit: got %b want 1", hit_o); end
        n_checks++; if (paddr_o !== 20'hDBEEF) begin n_errors++; $display("FAIL sup_paddr: got %h want dbeef", paddr_o); end
        idle();
        n_checks++; if (miss_o !== 1'b0) begin n_errors++; $display("FAIL sup_no_miss: got %b want 0", miss_o); end
        n_checks++; if (paddr_o !== 20'h0 || hit_o !== 1'b0) begin n_errors++; $display("FAIL no_req_idle: got hit=%b paddr=%h want hit=0 paddr=00000", hit_o, paddr_o); end
    endtask

    task automatic test_back_to_back();
        // Lookup and fill of the same VPN in one cycle: lookup sees pre-fill contents.
        drive(1'b1, 32'h0000_8123, 1'b0, 1'b0, 1'b1, 20'h00008, 8'h88);
        n_checks++; if (hit_o !== 1'b0) begin n_errors++; $display("FAIL same_cycle_fill_hit: got %b want 0", hit_o); end
        idle();
        n_checks++; if (miss_o !== 1'b1 || miss_vpn_o !== 20'h00008) begin n_errors++; $display("FAIL same_cycle_fill_miss: got miss=%b vpn=%h want miss=1 vpn=00008", miss_o, miss_vpn_o); end
        fill(20'h00008, 8'h88);
        lookup(32'h0000_8123);
        n_checks++; if (paddr_o !== 20'h88123 || hit_o !== 1'b1) begin n_errors++; $display("FAIL same_cycle_retry: got hit=%b paddr=%h want hit=1 paddr=88123", hit_o, paddr_o); end
        lookup(32'h0000_8FFF);
        n_checks++; if (paddr_o !== 20'h88FFF || hit_o !== 1'b1) begin n_errors++; $display("FAIL back_to_back_hit: got hit=%b paddr=%h want hit=1 paddr=88fff", hit_o, paddr_o); end
        idle();
    endtask

    initial begin
        test_reset();
        test_miss_then_fill();
        test_fifo_eviction();
        test_refill_existing();
        test_flush_fill();
        test_supervisor();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
